// File: rtl/vm_pkg.sv
// vm_pkg: state encoding, default widths and price-table slicing shared by the vending controller.
package vm_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, VEND = 2'd2, CHANGE = 2'd3} vm_state_t;
    localparam int NUM_PROD_D = 4;
    localparam int CREDIT_W_D = 6;
    localparam int COIN_W_D = 3;
    localparam int SEL_W_D = 2;
    localparam int STOCK_W_D = 4;
    localparam int TBL_MAX = 256;
    function automatic logic [31:0] price_slice(input logic [TBL_MAX-1:0] tbl, input int idx, input int w);
        return 32'(tbl >> (idx * w)) & ((32'd1 << w) - 32'd1);
    endfunction
endpackage

// File: rtl/vm_change_unit.sv
// vm_change_unit: credit register with coin add, price subtract and one-unit change handshake.
module vm_change_unit
    import vm_pkg::*;
#(
    parameter int CREDIT_W = CREDIT_W_D,
    parameter int COIN_W = COIN_W_D
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                add_en,
    input  logic [COIN_W-1:0]   coin_val,
    input  logic                sub_en,
    input  logic [CREDIT_W-1:0] sub_val,
    input  logic                chg_en,
    input  logic                change_ready,
    output logic                coin_ok,
    output logic                drain_done,
    output logic [CREDIT_W-1:0] credit,
    output logic                change_valid
);
    localparam logic [CREDIT_W:0] MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};
    logic [CREDIT_W:0] sum;
    logic [CREDIT_W-1:0] credit_nx;
    logic beat;
    assign sum = {1'b0, credit} + (CREDIT_W+1)'(coin_val);
    assign coin_ok = sum <= MAX_CREDIT;
    assign beat = change_valid && change_ready;
    assign credit_nx = add_en ? sum[CREDIT_W-1:0] :
                       sub_en ? credit - sub_val :
                       beat   ? credit - CREDIT_W'(1) : credit;
    assign drain_done = credit_nx == '0;
    // change_valid falls on the same edge that takes credit to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            credit <= '0;
            change_valid <= 1'b0;
        end else begin
            credit <= credit_nx;
            change_valid <= chg_en && !drain_done;
        end
    end
endmodule

// File: rtl/vm_multi_prod.sv
// vm_multi_prod: multi-product vending FSM with event arbitration; VM_STOCK_EN adds per-product stock counters.
module vm_multi_prod
    import vm_pkg::*;
#(
    parameter int NUM_PROD = NUM_PROD_D,
    parameter int CREDIT_W = CREDIT_W_D,
    parameter int COIN_W = COIN_W_D,
    parameter int SEL_W = SEL_W_D
`ifdef VM_STOCK_EN
    , parameter int STOCK_W = STOCK_W_D
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coin_valid,
    input  logic [COIN_W-1:0]            coin_val,
    input  logic                         sel_valid,
    input  logic [SEL_W-1:0]             sel_id,
    input  logic                         cancel,
    input  logic [NUM_PROD*CREDIT_W-1:0] price_tbl,
    input  logic                         change_ready,
`ifdef VM_STOCK_EN
    input  logic                         restock,
    input  logic [SEL_W-1:0]             restock_id,
    output logic [NUM_PROD-1:0]          sold_out,
`endif
    output logic                         dispense,
    output logic [SEL_W-1:0]             dispense_id,
    output logic                         change_valid,
    output logic                         coin_reject,
    output logic                         sel_err,
    output logic [CREDIT_W-1:0]          credit,
    output logic [1:0]                   state
);
    vm_state_t st, st_nx;
    logic [CREDIT_W-1:0] price;
    logic idle_col, coin_pres, do_cancel, sel_try, id_ok, in_stock, sel_ok, coin_try, add_en, coin_ok, drain_done;
    assign price = CREDIT_W'(price_slice(TBL_MAX'(price_tbl), int'(sel_id), CREDIT_W));
    assign idle_col = st == IDLE || st == COLLECT;
    assign coin_pres = coin_valid && coin_val != '0;
    assign do_cancel = idle_col && cancel && credit != '0;
    assign sel_try = idle_col && !cancel && sel_valid;
    assign id_ok = int'(sel_id) < NUM_PROD;
    assign sel_ok = sel_try && id_ok && in_stock && credit >= price;
    assign coin_try = idle_col && !cancel && !sel_valid && coin_pres;
    assign add_en = coin_try && coin_ok;
    assign state = st;
    always_comb begin
        st_nx = idle_col ? (do_cancel ? CHANGE : sel_ok ? VEND : add_en ? COLLECT : st) :
                st == VEND ? (credit != '0 ? CHANGE : IDLE) :
                (drain_done ? IDLE : CHANGE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            dispense <= 1'b0;
            dispense_id <= '0;
            coin_reject <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            st <= st_nx;
            dispense <= st_nx == VEND;
            dispense_id <= sel_ok ? sel_id : dispense_id;
            coin_reject <= coin_pres && !add_en;
            sel_err <= sel_valid && !sel_ok && !(idle_col && cancel);
        end
    end
    vm_change_unit #(.CREDIT_W(CREDIT_W), .COIN_W(COIN_W)) u_chg (
        .clk(clk),
        .rst(rst),
        .add_en(add_en),
        .coin_val(coin_val),
        .sub_en(sel_ok),
        .sub_val(price),
        .chg_en(st_nx == CHANGE),
        .change_ready(change_ready),
        .coin_ok(coin_ok),
        .drain_done(drain_done),
        .credit(credit),
        .change_valid(change_valid)
    );
`ifdef VM_STOCK_EN
    logic [STOCK_W-1:0] stock [NUM_PROD];
    logic [2**SEL_W-1:0] have;
    always_comb begin
        have = '0;
        for (int i = 0; i < NUM_PROD; i++) have[i] = stock[i] != '0;
    end
    assign in_stock = have[sel_id];
    assign sold_out = ~have[NUM_PROD-1:0];
    // restock takes precedence over the decrement of a concurrent dispense
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PROD; i++) begin
            if (rst) stock[i] <= '0;
            else if (restock && int'(restock_id) == i) stock[i] <= '1;
            else if (st == VEND && int'(dispense_id) == i) stock[i] <= stock[i] - STOCK_W'(1);
        end
    end
`else
    assign in_stock = 1'b1;
`endif
endmodule

// File: tb/tb_vm_multi_prod.sv
// tb_vm_multi_prod: directed self-checking bench for vm_multi_prod (main 4-product instance plus a 3-product instance).
module tb_vm_multi_prod;
    import vm_pkg::*;
    logic clk = 1'b0;
    logic rst, coin_valid, sel_valid, cancel, change_ready;
    logic [2:0] coin_val;
    logic [1:0] sel_id;
    logic [23:0] price_tbl = {6'd0, 6'd5, 6'd4, 6'd3};
    logic dispense, change_valid, coin_reject, sel_err;
    logic [1:0] dispense_id, state;
    logic [5:0] credit;
    logic dispense3, change_valid3, coin_reject3, sel_err3;
    logic [1:0] dispense_id3, state3;
    logic [5:0] credit3;
`ifdef VM_STOCK_EN
    logic restock;
    logic [1:0] restock_id;
    logic [3:0] sold_out;
    logic [2:0] sold_out3;
`endif
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    vm_multi_prod u_dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_val(coin_val),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .price_tbl(price_tbl),
        .change_ready(change_ready),
`ifdef VM_STOCK_EN
        .restock(restock), .restock_id(restock_id), .sold_out(sold_out),
`endif
        .dispense(dispense), .dispense_id(dispense_id), .change_valid(change_valid),
        .coin_reject(coin_reject), .sel_err(sel_err), .credit(credit), .state(state)
    );

    vm_multi_prod #(.NUM_PROD(3)) u_dut3 (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_val(coin_val),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .price_tbl(price_tbl[17:0]),
        .change_ready(change_ready),
`ifdef VM_STOCK_EN
        .restock(restock), .restock_id(restock_id), .sold_out(sold_out3),
`endif
        .dispense(dispense3), .dispense_id(dispense_id3), .change_valid(change_valid3),
        .coin_reject(coin_reject3), .sel_err(sel_err3), .credit(credit3), .state(state3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic coin(input logic [2:0] v);
        coin_valid = 1'b1;
        coin_val = v;
        tick();
        coin_valid = 1'b0;
        coin_val = '0;
    endtask

    task automatic sel(input logic [1:0] id);
        sel_valid = 1'b1;
        sel_id = id;
        tick();
        sel_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; coin_valid = 1'b0; coin_val = '0; sel_valid = 1'b0; sel_id = '0;
        cancel = 1'b0; change_ready = 1'b0;
`ifdef VM_STOCK_EN
        restock = 1'b0; restock_id = '0;
`endif
        tick(); tick();
        chk("rst_state", state, IDLE);
        chk("rst_credit", credit, 0);
        chk("rst_cv", change_valid, 0);
        chk("rst_disp", dispense, 0);
        rst = 1'b0;
`ifdef VM_STOCK_EN
        for (int i = 0; i < 4; i++) begin
            restock = 1'b1; restock_id = 2'(i); tick();
        end
        restock = 1'b0;
`endif
        coin(2); chk("c1_credit", credit, 2); chk("c1_state", state, COLLECT);
        coin(2); chk("c2_credit", credit, 4);
        coin(1); chk("c3_credit", credit, 5);
        sel(2);
        chk("v1_disp", dispense, 1); chk("v1_id", dispense_id, 2);
        chk("v1_credit", credit, 0); chk("v1_state", state, VEND);
        tick();
        chk("v1_idle", state, IDLE); chk("v1_pulse", dispense, 0); chk("v1_cv", change_valid, 0);

        coin(7); chk("v2_credit7", credit, 7);
        sel(2); chk("v2_disp", dispense, 1); chk("v2_credit", credit, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("v2_hold_state", state, CHANGE); chk("v2_hold_cv", change_valid, 1); chk("v2_hold_credit", credit, 2);
        end
        change_ready = 1'b1;
        tick(); chk("v2_beat1", credit, 1); chk("v2_cv1", change_valid, 1);
        tick(); chk("v2_beat2", credit, 0); chk("v2_cv0", change_valid, 0); chk("v2_idle", state, IDLE);
        change_ready = 1'b0;

        for (int i = 0; i < 8; i++) coin(7);
        coin(4); chk("sat_60", credit, 60);
        coin(5); chk("sat_rej", coin_reject, 1); chk("sat_hold", credit, 60);
        coin(3); chk("sat_63", credit, 63); chk("sat_norej", coin_reject, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("sat_clr", credit, 0);

        coin(3);
        sel(2); chk("lo_err", sel_err, 1); chk("lo_credit", credit, 3); chk("lo_state", state, COLLECT);
        cancel = 1'b1; coin_valid = 1'b1; coin_val = 3'd1; tick();
        cancel = 1'b0; coin_valid = 1'b0; coin_val = '0;
        chk("can_rej", coin_reject, 1); chk("can_state", state, CHANGE); chk("can_cv", change_valid, 1);
        change_ready = 1'b1;
        tick(); chk("can_b1", credit, 2);
        tick(); chk("can_b2", credit, 1);
        tick(); chk("can_b3", credit, 0); chk("can_idle", state, IDLE); chk("can_cv0", change_valid, 0);
        change_ready = 1'b0;

        coin(4);
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("mr_state", state, CHANGE); chk("mr_credit", credit, 4);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mr_credit0", credit, 0); chk("mr_cv0", change_valid, 0); chk("mr_idle", state, IDLE);

        sel(3);
        chk("p0_disp", dispense, 1); chk("p0_id", dispense_id, 3); chk("p0_credit", credit, 0);
        chk("np3_err", sel_err3, 1); chk("np3_nodisp", dispense3, 0);
        tick(); chk("p0_idle", state, IDLE);

`ifdef VM_STOCK_EN
        restock = 1'b1; restock_id = 2'd1; tick(); restock = 1'b0;
        for (int i = 0; i < 15; i++) begin
            coin(4); sel(1); chk("stk_disp", dispense, 1); tick();
        end
        chk("stk_sold", sold_out[1], 1);
        coin(4); sel(1);
        chk("stk_err", sel_err, 1); chk("stk_credit", credit, 4);
        restock = 1'b1; restock_id = 2'd1; tick(); restock = 1'b0;
        chk("stk_refill", sold_out[1], 0);
        sel(1); chk("stk_vend", state, VEND);
        restock = 1'b1; restock_id = 2'd1; tick(); restock = 1'b0;
        chk("stk_idle", state, IDLE);
        for (int i = 0; i < 15; i++) begin
            coin(4); sel(1); tick();
            chk("stk_cnt", sold_out[1], 32'(i == 14));
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vm_multi_prod.md
Name: vm_multi_prod

Overview:
- Parametrised vending controller, successor to the fixed 3-state, 2-product-price machine.
- Supports NUM_PROD products, each with a runtime price, and accumulates coin credit in a saturating-checked register.
- Dispenses on a valid selection and returns change one unit at a time over a valid/ready handshake.
- Sits between the coin acceptor front-end and the dispense/change actuator drivers.

Parameters:
- NUM_PROD, 4, number of selectable products (>=2).
- CREDIT_W, 6, credit/price width in coin units; maximum credit MAX_CREDIT = 2^CREDIT_W-1.
- COIN_W, 3, width of coin value input in units.
- SEL_W, 2, width of product select; must satisfy 2^SEL_W >= NUM_PROD.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- coin_valid  in  1  coin inserted this cycle.
- coin_val  in  COIN_W  coin value in units; 0 is treated as no coin.
- sel_valid  in  1  product selection strobe.
- sel_id  in  SEL_W  selected product index.
- cancel  in  1  refund request.
- price_tbl  in  NUM_PROD*CREDIT_W  packed prices; product i at bits [i*CREDIT_W +: CREDIT_W]; quasi-static.
- change_ready  in  1  actuator accepts one change unit.
- dispense  out  1  one-cycle pulse, product released.
- dispense_id  out  SEL_W  product index, valid with dispense.
- change_valid  out  1  change unit pending.
- coin_reject  out  1  one-cycle pulse, coin not credited.
- sel_err  out  1  one-cycle pulse, selection refused.
- credit  out  CREDIT_W  current credit.
- state  out  2  FSM state for debug.

Behaviour:
- FSM states:
  - IDLE=0: credit is 0.
  - COLLECT=1: credit > 0.
  - VEND=2: one cycle.
  - CHANGE=3: returning change.
- Reset: state=IDLE, credit=0, and all pulse outputs plus change_valid are 0. Reset mid-operation discards credit with no refund.
- All outputs are registered. Each pulse is driven the cycle after the causing event.
- Event priority in IDLE/COLLECT: cancel > sel_valid > coin_valid. A lower-priority coin in the same cycle is dropped and pulses coin_reject.
- Coin handling: accepted if credit+coin_val <= MAX_CREDIT. Compute the sum at CREDIT_W+1 bits. On accept, credit += coin_val and state goes to COLLECT. Otherwise credit is unchanged and coin_reject pulses.
- Selection: sel_id >= NUM_PROD, or credit < price, pulses sel_err with no state change. Otherwise the FSM goes to VEND and credit -= price.
- VEND: dispense=1, dispense_id=latched sel_id.
  - Next state is CHANGE if the remaining credit > 0, else IDLE.
  - A price of 0 is legal and dispenses from IDLE.
- cancel: CHANGE if credit > 0; ignored in IDLE.
- CHANGE:
  - change_valid=1 while credit > 0.
  - Each cycle with change_valid && change_ready decrements credit by 1.
  - When credit reaches 0, change_valid drops the same cycle and the FSM goes to IDLE.
  - change_valid must stay high while ready is low.
- During VEND/CHANGE: coins pulse coin_reject, selections pulse sel_err, cancel is ignored.

Optional Feature:
- Macro: VM_STOCK_EN.
- When defined:
  - Adds parameter STOCK_W (default 4).
  - Adds input restock (1) and input restock_id (SEL_W).
  - Adds output sold_out (NUM_PROD bits).
  - Per-product counters reset to 0. Restock sets the counter to 2^STOCK_W-1.
  - A dispense decrements the counter of the dispensed product.
  - Selection of a product with stock 0 pulses sel_err and leaves credit intact.
  - If restock and dispense hit the same id in the same cycle, restock wins.
- When undefined: unlimited stock, and none of these ports exist.

Decomposition:
- Package vm_pkg holds:
  - the state encoding (IDLE/COLLECT/VEND/CHANGE);
  - the default width constants;
  - the price-slice helper function.
- One sub-module, vm_change_unit, contains the credit register, add/subtract/decrement arithmetic and the change handshake.
- The top level contains the FSM and event arbitration.

Test Plan:
- NUM_PROD=4, price[2]=5; coins 2,2,1, then sel 2 -> credit goes 2,4,5; dispense with id 2 one cycle after sel; credit 0; IDLE; no change_valid.
- Credit 7, sel price 5 -> dispense, then CHANGE. change_ready held low 3 cycles then high -> change_valid held high throughout; 2 accepted beats; credit 2->1->0; IDLE.
- Credit 60, coin 5 -> coin_reject, credit stays 60. Then coin 3 -> credit 63 (MAX_CREDIT).
- Credit 3, sel price 5 -> sel_err, credit 3, state COLLECT. Then cancel with coin_valid in the same cycle -> coin_reject; 3 change beats; IDLE.
- Reset asserted in CHANGE with credit 4 -> next cycle credit 0, change_valid 0, IDLE. Also sel_id=3 with NUM_PROD=3 -> sel_err.
- VM_STOCK_EN: restock id 1, then 15 vends of id 1 -> 16th sel pulses sel_err and sold_out[1]=1. Simultaneous restock and dispense of id 1 -> count becomes 15.
